// File: rtl/sat_engine_pkg.sv
// Shared types and helpers for the SAT engine datapath.
// Holds the state_loader FSM encoding and state-RAM address composition.
package sat_engine_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RD   = 2'd1,
    LOAD_TAIL = 2'd2,
    UPD_WR    = 2'd3
  } state_t;

  // State-RAM word address is {bin_id, idx}; callers truncate to width.
  function automatic logic [31:0] state_addr(
    input logic [31:0] bin_id,
    input logic [31:0] idx,
    input int unsigned idx_w
  );
    return (bin_id << idx_w) | idx;
  endfunction

endpackage

// File: rtl/state_loader_ctrl.sv
// state_loader sequencing: FSM, entry index counter and the
// registered strobe pipeline that lines up with 1-cycle RAM reads.
module state_loader_ctrl
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_IDX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_load_i,
  input  logic                 start_update_i,
  output logic                 busy_o,
  output logic                 load_go_o,
  output logic                 upd_go_o,
  output logic                 done_load_o,
  output logic                 done_update_o,
  output logic                 rd_en_o,
  output logic                 wr_en_o,
  output logic [WIDTH_IDX-1:0] idx_o,
  output logic                 strb_vld_o,
  output logic [WIDTH_IDX-1:0] strb_idx_o
);

  localparam logic [WIDTH_IDX-1:0] LAST = WIDTH_IDX'(NUM_VARS - 1);

  state_t               state, state_n;
  logic [WIDTH_IDX-1:0] idx, idx_n;
  logic                 done_l_n, done_u_n;

  // Next-state, index advance and start acceptance.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    done_l_n  = 1'b0;
    done_u_n  = 1'b0;
    load_go_o = 1'b0;
    upd_go_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_load_i) begin
          load_go_o = 1'b1;
          state_n   = LOAD_RD;
          idx_n     = '0;
        end else if (start_update_i) begin
          upd_go_o = 1'b1;
          state_n  = UPD_WR;
          idx_n    = '0;
        end
      end
      LOAD_RD: begin
        if (idx == LAST) state_n = LOAD_TAIL;
        else idx_n = idx + 1'b1;
      end
      LOAD_TAIL: begin
        state_n  = IDLE;
        done_l_n = 1'b1;
      end
      UPD_WR: begin
        if (idx == LAST) begin
          state_n  = IDLE;
          done_u_n = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
    endcase
  end

  // State, enables, done pulses and the read-to-strobe delay stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      rd_en_o       <= 1'b0;
      wr_en_o       <= 1'b0;
      done_load_o   <= 1'b0;
      done_update_o <= 1'b0;
      strb_vld_o    <= 1'b0;
      strb_idx_o    <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      rd_en_o       <= (state_n == LOAD_RD);
      wr_en_o       <= (state_n == UPD_WR);
      done_load_o   <= done_l_n;
      done_update_o <= done_u_n;
      strb_vld_o    <= rd_en_o;
      strb_idx_o    <= idx;
    end
  end

  assign busy_o = (state != IDLE);
  assign idx_o  = idx;

endmodule

// File: rtl/state_loader.sv
// Moves one bin's var/lvl states between the state RAMs and state_list.
// Optional STATE_LOADER_DIRTY_EN skips write-back of unchanged entries.
module state_loader
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 11,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_IDX        = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_load_i,
  input  logic                                 start_update_i,
  input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
  output logic                                 busy_o,
  output logic                                 done_load_o,
  output logic                                 done_update_o,
  output logic [NUM_VARS-1:0]                  wr_var_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_o,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_i,
  output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  output logic                                 vs_rd_en_o,
  output logic                                 ls_rd_en_o,
  output logic                                 vs_wr_en_o,
  output logic                                 ls_wr_en_o,
  output logic [WIDTH_BIN_ID+WIDTH_IDX-1:0]    vs_addr_o,
  output logic [WIDTH_BIN_ID+WIDTH_IDX-1:0]    ls_addr_o,
  input  logic [WIDTH_VAR_STATES-1:0]          vs_rdata_i,
  input  logic [WIDTH_LVL_STATES-1:0]          ls_rdata_i,
  output logic [WIDTH_VAR_STATES-1:0]          vs_wdata_o,
  output logic [WIDTH_LVL_STATES-1:0]          ls_wdata_o
);

  localparam int WA = WIDTH_BIN_ID + WIDTH_IDX;

  if (NUM_VARS != NUM_LVLS) begin : g_bad_cfg
    $error("state_loader: NUM_VARS must equal NUM_LVLS");
  end

  logic                        load_go, upd_go, rd_en, wr_en, strb_vld;
  logic [WIDTH_IDX-1:0]        idx, strb_idx;
  logic [WIDTH_BIN_ID-1:0]     bin_id_r;
  logic [WIDTH_VAR_STATES-1:0] snap_v [NUM_VARS];
  logic [WIDTH_LVL_STATES-1:0] snap_l [NUM_LVLS];

  state_loader_ctrl #(
    .NUM_VARS  (NUM_VARS),
    .WIDTH_IDX (WIDTH_IDX)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .start_load_i   (start_load_i),
    .start_update_i (start_update_i),
    .busy_o         (busy_o),
    .load_go_o      (load_go),
    .upd_go_o       (upd_go),
    .done_load_o    (done_load_o),
    .done_update_o  (done_update_o),
    .rd_en_o        (rd_en),
    .wr_en_o        (wr_en),
    .idx_o          (idx),
    .strb_vld_o     (strb_vld),
    .strb_idx_o     (strb_idx)
  );

  // Latch the bin on any accepted start; snapshot state_list on update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_id_r <= '0;
      for (int k = 0; k < NUM_VARS; k++) snap_v[k] <= '0;
      for (int k = 0; k < NUM_LVLS; k++) snap_l[k] <= '0;
    end else begin
      if (load_go || upd_go) bin_id_r <= bin_id_i;
      if (upd_go) begin
        for (int k = 0; k < NUM_VARS; k++)
          snap_v[k] <= var_states_i[k*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
        for (int k = 0; k < NUM_LVLS; k++)
          snap_l[k] <= lvl_states_i[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
      end
    end
  end

  assign vs_addr_o  = WA'(state_addr(32'(bin_id_r), 32'(idx), WIDTH_IDX));
  assign ls_addr_o  = vs_addr_o;
  assign vs_rd_en_o = rd_en;
  assign ls_rd_en_o = rd_en;
  assign vs_wdata_o = snap_v[idx];
  assign ls_wdata_o = snap_l[idx];

`ifdef STATE_LOADER_DIRTY_EN
  logic [WIDTH_VAR_STATES-1:0] shd_v [NUM_VARS];
  logic [WIDTH_LVL_STATES-1:0] shd_l [NUM_LVLS];

  // Shadow copy of what was last loaded, used to skip clean entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_VARS; k++) shd_v[k] <= '0;
      for (int k = 0; k < NUM_LVLS; k++) shd_l[k] <= '0;
    end else if (strb_vld) begin
      shd_v[strb_idx] <= vs_rdata_i;
      shd_l[strb_idx] <= ls_rdata_i;
    end
  end

  assign vs_wr_en_o = wr_en && (snap_v[idx] != shd_v[idx]);
  assign ls_wr_en_o = wr_en && (snap_l[idx] != shd_l[idx]);
`else
  assign vs_wr_en_o = wr_en;
  assign ls_wr_en_o = wr_en;
`endif

  // One-hot strobe and replicated RAM data, live only when data arrives.
  always_comb begin
    wr_var_states_o = '0;
    wr_lvl_states_o = '0;
    var_states_o    = '0;
    lvl_states_o    = '0;
    if (strb_vld) begin
      wr_var_states_o[strb_idx] = 1'b1;
      wr_lvl_states_o[strb_idx] = 1'b1;
      var_states_o = {NUM_VARS{vs_rdata_i}};
      lvl_states_o = {NUM_LVLS{ls_rdata_i}};
    end
  end

endmodule

// File: tb/tb_state_loader.sv
// Scoreboard bench for state_loader: directed loads/updates,
// expectations queued at issue time and checked by a monitor.
module tb_state_loader;

  localparam int NV = 8;
  localparam int NL = 8;
  localparam int WV = 19;
  localparam int WL = 11;
  localparam int WB = 10;
  localparam int WI = 3;
  localparam int WA = WB + WI;

  logic            clk, rst;
  logic            start_load_i, start_update_i;
  logic [WB-1:0]   bin_id_i;
  logic            busy_o, done_load_o, done_update_o;
  logic [NV-1:0]   wr_var_states_o;
  logic [WV*NV-1:0] var_states_o, var_states_i;
  logic [NL-1:0]   wr_lvl_states_o;
  logic [WL*NL-1:0] lvl_states_o, lvl_states_i;
  logic            vs_rd_en_o, ls_rd_en_o, vs_wr_en_o, ls_wr_en_o;
  logic [WA-1:0]   vs_addr_o, ls_addr_o;
  logic [WV-1:0]   vs_rdata_i, vs_wdata_o;
  logic [WL-1:0]   ls_rdata_i, ls_wdata_o;

  state_loader dut (
    .clk             (clk),
    .rst             (rst),
    .start_load_i    (start_load_i),
    .start_update_i  (start_update_i),
    .bin_id_i        (bin_id_i),
    .busy_o          (busy_o),
    .done_load_o     (done_load_o),
    .done_update_o   (done_update_o),
    .wr_var_states_o (wr_var_states_o),
    .var_states_o    (var_states_o),
    .var_states_i    (var_states_i),
    .wr_lvl_states_o (wr_lvl_states_o),
    .lvl_states_o    (lvl_states_o),
    .lvl_states_i    (lvl_states_i),
    .vs_rd_en_o      (vs_rd_en_o),
    .ls_rd_en_o      (ls_rd_en_o),
    .vs_wr_en_o      (vs_wr_en_o),
    .ls_wr_en_o      (ls_wr_en_o),
    .vs_addr_o       (vs_addr_o),
    .ls_addr_o       (ls_addr_o),
    .vs_rdata_i      (vs_rdata_i),
    .ls_rdata_i      (ls_rdata_i),
    .vs_wdata_o      (vs_wdata_o),
    .ls_wdata_o      (ls_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WV-1:0] vmem [0:(1<<WA)-1];
  logic [WL-1:0] lmem [0:(1<<WA)-1];
  logic [WV-1:0] vin [NV];
  logic [WL-1:0] lin [NL];

  // Read-only RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (vs_rd_en_o) vs_rdata_i <= vmem[vs_addr_o];
    if (ls_rd_en_o) ls_rdata_i <= lmem[ls_addr_o];
  end

  always_comb begin
    var_states_i = '0;
    lvl_states_i = '0;
    for (int k = 0; k < NV; k++) var_states_i[k*WV +: WV] = vin[k];
    for (int k = 0; k < NL; k++) lvl_states_i[k*WL +: WL] = lin[k];
  end

  typedef struct {
    int            cyc;
    int            k;
    logic [WA-1:0] addr;
    logic [WV-1:0] v;
    logic [WL-1:0] l;
  } exp_t;

  exp_t q_s[$];
  exp_t q_vw[$];
  exp_t q_lw[$];
  int   q_dl[$];
  int   q_du[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s @cyc %0d: got unexpected event expected none", nm, cyc);
  endtask

  // Monitor: pops the matching expectation whenever the DUT acts.
  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (!rst) begin
      if (wr_var_states_o != '0 || wr_lvl_states_o != '0) begin
        if (q_s.size() == 0) unexpected("strobe");
        else begin
          e = q_s.pop_front();
          chk("strb_cyc", 256'(cyc), 256'(e.cyc));
          chk("wr_var", 256'(wr_var_states_o), 256'(1) << e.k);
          chk("wr_lvl", 256'(wr_lvl_states_o), 256'(1) << e.k);
          chk("var_states", 256'(var_states_o), 256'({NV{e.v}}));
          chk("lvl_states", 256'(lvl_states_o), 256'({NL{e.l}}));
        end
      end
      if (vs_wr_en_o) begin
        if (q_vw.size() == 0) unexpected("vs_wr");
        else begin
          e = q_vw.pop_front();
          chk("vs_wr_cyc", 256'(cyc), 256'(e.cyc));
          chk("vs_addr", 256'(vs_addr_o), 256'(e.addr));
          chk("vs_wdata", 256'(vs_wdata_o), 256'(e.v));
        end
      end
      if (ls_wr_en_o) begin
        if (q_lw.size() == 0) unexpected("ls_wr");
        else begin
          e = q_lw.pop_front();
          chk("ls_wr_cyc", 256'(cyc), 256'(e.cyc));
          chk("ls_addr", 256'(ls_addr_o), 256'(e.addr));
          chk("ls_wdata", 256'(ls_wdata_o), 256'(e.l));
        end
      end
      if (done_load_o) begin
        if (q_dl.size() == 0) unexpected("done_load");
        else begin
          c = q_dl.pop_front();
          chk("done_load_cyc", 256'(cyc), 256'(c));
        end
      end
      if (done_update_o) begin
        if (q_du.size() == 0) unexpected("done_update");
        else begin
          c = q_du.pop_front();
          chk("done_update_cyc", 256'(cyc), 256'(c));
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"},
        256'({busy_o, done_load_o, done_update_o, wr_var_states_o,
              wr_lvl_states_o, vs_rd_en_o, ls_rd_en_o, vs_wr_en_o,
              ls_wr_en_o, vs_addr_o, ls_addr_o, vs_wdata_o, ls_wdata_o}),
        256'(0));
    chk({nm, "_data"}, 256'({var_states_o, lvl_states_o}), 256'(0));
  endtask

  // Called at a negedge; start is sampled at the next posedge (T0).
  task automatic do_load(input int bin, input int vb, input int lb,
                         input int nstrb, input bit with_done,
                         input bit with_upd);
    exp_t e;
    int   n;
    n = cyc;
    for (int k = 0; k < nstrb; k++) begin
      e.cyc  = n + 2 + k;
      e.k    = k;
      e.addr = '0;
      e.v    = WV'(vb + k);
      e.l    = WL'(lb + k);
      q_s.push_back(e);
    end
    if (with_done) q_dl.push_back(n + 2 + NV);
    bin_id_i       = WB'(bin);
    start_load_i   = 1'b1;
    start_update_i = with_upd;
    @(negedge clk);
    start_load_i   = 1'b0;
    start_update_i = 1'b0;
  endtask

  task automatic do_update(input int bin, input logic [NV-1:0] vmask,
                           input logic [NL-1:0] lmask);
    exp_t e;
    int   n;
    n = cyc;
    for (int k = 0; k < NV; k++) begin
      e.cyc  = n + 1 + k;
      e.k    = k;
      e.addr = {WB'(bin), WI'(k)};
      e.v    = vin[k];
      e.l    = lin[k];
      if (vmask[k]) q_vw.push_back(e);
      if (lmask[k]) q_lw.push_back(e);
    end
    q_du.push_back(n + 1 + NV);
    bin_id_i       = WB'(bin);
    start_update_i = 1'b1;
    @(negedge clk);
    start_update_i = 1'b0;
  endtask

  logic [NV-1:0] dvm;
  logic [NL-1:0] dlm;

  initial begin
    rst = 1'b1;
    start_load_i = 1'b0;
    start_update_i = 1'b0;
    bin_id_i = '0;
    for (int a = 0; a < (1 << WA); a++) begin
      vmem[a] = '0;
      lmem[a] = '0;
    end
    for (int k = 0; k < NV; k++) begin
      vmem[{WB'(5), WI'(k)}] = WV'(32'h100 + k);
      lmem[{WB'(5), WI'(k)}] = WL'(32'h40 + k);
      vmem[{WB'(6), WI'(k)}] = WV'(32'h500 + k);
      lmem[{WB'(6), WI'(k)}] = WL'(32'h50 + k);
      vin[k] = '0;
      lin[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Load bin 5 with busy boundary checks.
    do_load(5, 'h100, 'h40, NV, 1'b1, 1'b0);
    chk("busy_load_T1", 256'(busy_o), 256'(1));
    repeat (8) @(negedge clk);
    chk("busy_load_T9", 256'(busy_o), 256'(1));
    @(negedge clk);
    chk("busy_load_T10", 256'(busy_o), 256'(0));
    repeat (3) @(negedge clk);

    // Update bin 3; inputs change mid-update, snapshot must hold.
    for (int k = 0; k < NV; k++) begin
      vin[k] = WV'(32'h200 + k);
      lin[k] = WL'(32'h20 + k);
    end
    do_update(3, '1, '1);
    for (int k = 0; k < NV; k++) begin
      vin[k] = WV'(32'h7FF00 + k);
      lin[k] = WL'(32'h7F0 + k);
    end
    repeat (7) @(negedge clk);
    chk("busy_upd_T8", 256'(busy_o), 256'(1));
    @(negedge clk);
    chk("busy_upd_T9", 256'(busy_o), 256'(0));
    repeat (3) @(negedge clk);

    // Both starts together: load bin 6 wins; a later update is ignored.
    do_load(6, 'h500, 'h50, NV, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    bin_id_i = WB'(2);
    start_update_i = 1'b1;
    @(negedge clk);
    start_update_i = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the middle of a load: no done, outputs cleared.
    do_load(5, 'h100, 'h40, 2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_load(5, 'h100, 'h40, NV, 1'b1, 1'b0);
    repeat (12) @(negedge clk);

    // Back-to-back: update issued in the done_load cycle.
    do_load(5, 'h100, 'h40, NV, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    chk("b2b_done_load", 256'(done_load_o), 256'(1));
    for (int k = 0; k < NV; k++) begin
      vin[k] = WV'(32'h600 + k);
      lin[k] = WL'(32'h60 + k);
    end
    do_update(7, '1, '1);
    repeat (12) @(negedge clk);

    // Only var slice 2 differs from what was loaded.
    do_load(5, 'h100, 'h40, NV, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    for (int k = 0; k < NV; k++) begin
      vin[k] = WV'(32'h100 + k);
      lin[k] = WL'(32'h40 + k);
    end
    vin[2] = WV'(32'h1AB);
`ifdef STATE_LOADER_DIRTY_EN
    dvm = 8'b0000_0100;
    dlm = 8'b0000_0000;
`else
    dvm = 8'hFF;
    dlm = 8'hFF;
`endif
    do_update(5, dvm, dlm);
    repeat (12) @(negedge clk);

    chk("left_strobes", 256'(q_s.size()), 256'(0));
    chk("left_vs_wr", 256'(q_vw.size()), 256'(0));
    chk("left_ls_wr", 256'(q_lw.size()), 256'(0));
    chk("left_done_load", 256'(q_dl.size()), 256'(0));
    chk("left_done_upd", 256'(q_du.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
